// File: rtl/dcache_refill_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dcache_refill_buf_if : request / beat-return / line-handoff bundle |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface dcache_refill_buf_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              ret_valid;
   logic              ret_last;
   logic [31:0]       ret_data;
   logic              crit_valid;
   logic [31:0]       crit_data;
   logic              line_valid;
   logic              line_ready;
   logic [127:0]      line_data;
   logic [ADDR_W-1:0] line_addr;
   logic              line_err;

   // Cache-side view: issues requests and beats, consumes the line.
   modport master (
      output req_valid, req_addr, ret_valid, ret_last, ret_data, line_ready,
      input  req_ready, crit_valid, crit_data, line_valid, line_data, line_addr, line_err
   );

   modport slave (
      input  req_valid, req_addr, ret_valid, ret_last, ret_data, line_ready,
      output req_ready, crit_valid, crit_data, line_valid, line_data, line_addr, line_err
   );
endinterface
`default_nettype wire

// File: rtl/dcache_refill_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dcache_refill_buf : assembles four 32-bit refill beats into a line |
// | and early-forwards the critical word. Revision 1.0                 |
// +--------------------------------------------------------------------+
module dcache_refill_buf #(
   parameter int ADDR_W = 32
) (
   input  wire logic          clk,
   input  wire logic          rst,
   dcache_refill_buf_if.slave bus
);
   localparam logic [1:0] LAST_WORD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        ci_q, ci_d;
   logic              full_q, full_d;
   logic              err_q, err_d;
   logic [127:0]      line_q, line_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              crit_valid_q, crit_valid_d;
   logic [31:0]       crit_data_q, crit_data_d;
   logic              req_ready_q, req_ready_d;
   logic              line_valid_q, line_valid_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         ci_q         <= 2'd0;
         full_q       <= 1'b0;
         err_q        <= 1'b0;
         line_q       <= '0;
         addr_q       <= '0;
         crit_valid_q <= 1'b0;
         crit_data_q  <= '0;
         req_ready_q  <= 1'b1;
         line_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ci_q         <= ci_d;
         full_q       <= full_d;
         err_q        <= err_d;
         line_q       <= line_d;
         addr_q       <= addr_d;
         crit_valid_q <= crit_valid_d;
         crit_data_q  <= crit_data_d;
         req_ready_q  <= req_ready_d;
         line_valid_q <= line_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ci_d         = ci_q;
      full_d       = full_q;
      err_d        = err_q;
      line_d       = line_q;
      addr_d       = addr_q;
      crit_valid_d = 1'b0;
      crit_data_d  = crit_data_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = {bus.req_addr[ADDR_W-1:4], 4'h0};
               ci_d    = bus.req_addr[3:2];
               cnt_d   = 2'd0;
               full_d  = 1'b0;
               err_d   = 1'b0;
               line_d  = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            if (bus.ret_valid) begin
               // full_q distinguishes "three beats in" from "four beats in",
               // since cnt saturates at 3 in both cases.
               if (full_q) begin
                  err_d = 1'b1;
               end else begin
                  line_d[{cnt_q, 5'd0} +: 32] = bus.ret_data;
                  if (cnt_q == ci_q) begin
                     crit_valid_d = 1'b1;
                     crit_data_d  = bus.ret_data;
                  end
                  if (cnt_q == LAST_WORD) begin
                     full_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end
               if (bus.ret_last) begin
                  state_d = DONE;
                  if (!full_q && cnt_q != LAST_WORD) begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            if (bus.line_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready_d  = (state_d == IDLE);
   assign line_valid_d = (state_d == DONE);

   assign bus.req_ready  = req_ready_q;
   assign bus.crit_valid = crit_valid_q;
   assign bus.crit_data  = crit_data_q;
   assign bus.line_valid = line_valid_q;
   assign bus.line_data  = line_q;
   assign bus.line_addr  = addr_q;
   assign bus.line_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_dcache_refill_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dcache_refill_buf : directed and random refills against a       |
// | transaction-level model. Revision 1.0                              |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dcache_refill_buf;
   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_refill_buf_if #(.ADDR_W(ADDR_W)) bus ();
   dcache_refill_buf #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 collecting, 2 line held. Beats are simply
   // counted; the line is the first four, and the error is "not exactly four".
   int              m_phase;
   int              m_n;
   int              m_ci;
   logic [31:0]     m_words [4];
   logic [ADDR_W-1:0] m_addr;
   logic            m_crit;
   logic [31:0]     m_crit_data;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase     <= 0;
         m_n         <= 0;
         m_ci        <= 0;
         m_addr      <= '0;
         m_crit      <= 1'b0;
         m_crit_data <= '0;
         for (int i = 0; i < 4; i++) m_words[i] <= '0;
      end else begin
         m_crit <= 1'b0;
         case (m_phase)
            0: if (bus.req_valid) begin
               m_phase <= 1;
               m_n     <= 0;
               m_ci    <= int'(bus.req_addr[3:2]);
               m_addr  <= {bus.req_addr[ADDR_W-1:4], 4'h0};
               for (int i = 0; i < 4; i++) m_words[i] <= '0;
            end
            1: if (bus.ret_valid) begin
               if (m_n < 4) begin
                  m_words[m_n] <= bus.ret_data;
                  if (m_n == m_ci) begin
                     m_crit      <= 1'b1;
                     m_crit_data <= bus.ret_data;
                  end
               end
               m_n <= m_n + 1;
               if (bus.ret_last) m_phase <= 2;
            end
            default: if (bus.line_ready) m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("req_ready", bus.req_ready, m_phase == 0);
      check("line_valid", bus.line_valid, m_phase == 2);
      check("crit_valid", bus.crit_valid, m_crit);
      if (m_crit) check("crit_data", bus.crit_data, m_crit_data);
      if (m_phase == 2) begin
         check("line_data", bus.line_data, {m_words[3], m_words[2], m_words[1], m_words[0]});
         check("line_addr", bus.line_addr, m_addr);
         check("line_err", bus.line_err, m_n != 4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] a);
      int k = 0;
      bus.ret_valid = 1'($urandom);
      bus.ret_data  = $urandom;
      tick();
      bus.ret_valid = 1'b0;
      while (!bus.req_ready && k < 50) begin
         tick();
         k++;
      end
      if (!bus.req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
      end
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      tick();
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
   endtask

   task automatic beat(input logic [31:0] d, input bit last, input int gap);
      bus.ret_valid = 1'b1;
      bus.ret_data  = d;
      bus.ret_last  = last;
      tick();
      bus.ret_valid = 1'b0;
      bus.ret_last  = 1'($urandom);
      bus.ret_data  = $urandom;
      repeat (gap) tick();
   endtask

   task automatic finish_line(input int hold, input bit noise);
      int k = 0;
      while (!bus.line_valid && k < 50) begin
         tick();
         k++;
      end
      if (!bus.line_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL line_valid_timeout: got 0 expected 1");
      end
      repeat (hold) begin
         if (noise) begin
            bus.req_valid = 1'($urandom);
            bus.ret_valid = 1'($urandom);
            bus.ret_data  = $urandom;
         end
         tick();
      end
      bus.req_valid  = 1'b0;
      bus.ret_valid  = 1'b0;
      bus.line_ready = 1'b1;
      tick();
      bus.line_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] l1;
      int           n;
      l1 = 128'h44444444_33333333_22222222_11111111;
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus.ret_valid  = 1'b0;
      bus.ret_last   = 1'b0;
      bus.ret_data   = '0;
      bus.line_ready = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_line_valid", bus.line_valid, 0);
      check("rst_line_data", bus.line_data, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      tick();

      // Clean fill, critical word is word 2
      start(32'h1C000048);
      beat(32'h11111111, 0, 0);
      beat(32'h22222222, 0, 0);
      beat(32'h33333333, 0, 0);
      check("clean_crit_valid", bus.crit_valid, 1);
      check("clean_crit_data", bus.crit_data, 32'h33333333);
      beat(32'h44444444, 1, 0);
      check("clean_line_valid", bus.line_valid, 1);
      check("clean_line_data", bus.line_data, l1);
      check("clean_line_addr", bus.line_addr, 32'h1C000040);
      check("clean_line_err", bus.line_err, 0);

      // Hold the line with noise on the ignored inputs
      for (int i = 0; i < 10; i++) begin
         bus.req_valid = 1'($urandom);
         bus.ret_valid = 1'($urandom);
         bus.ret_last  = 1'($urandom);
         bus.ret_data  = $urandom;
         tick();
         check("hold_req_ready", bus.req_ready, 0);
         check("hold_line_data", bus.line_data, l1);
      end
      bus.req_valid  = 1'b0;
      bus.ret_valid  = 1'b0;
      bus.line_ready = 1'b1;
      tick();
      bus.line_ready = 1'b0;
      check("handoff_req_ready", bus.req_ready, 1);
      check("handoff_line_valid", bus.line_valid, 0);

      // Short burst with critical word 3: no forward, error, upper words zero
      start(32'h0000200C);
      beat(32'hAAAA0001, 0, 0);
      beat(32'hAAAA0002, 1, 0);
      check("short_crit_valid", bus.crit_valid, 0);
      check("short_line_err", bus.line_err, 1);
      check("short_upper_zero", bus.line_data[127:64], 0);
      check("short_lower", bus.line_data[63:0], 64'hAAAA0002_AAAA0001);
      finish_line(0, 0);

      // Long burst: fifth beat dropped
      start(32'h00003004);
      for (int i = 0; i < 4; i++) beat(32'hB0000000 + i, 0, 0);
      beat(32'hBEEFBEEF, 1, 0);
      check("long_word3", bus.line_data[127:96], 32'hB0000003);
      check("long_line_err", bus.line_err, 1);
      finish_line(0, 0);

      // Stalled beats, critical word 0
      start(32'h1C000040);
      beat(32'h11111111, 0, 0);
      check("stall_crit_valid", bus.crit_valid, 1);
      check("stall_crit_data", bus.crit_data, 32'h11111111);
      repeat (3) tick();
      beat(32'h22222222, 0, 3);
      beat(32'h33333333, 0, 3);
      beat(32'h44444444, 1, 0);
      check("stall_line_data", bus.line_data, l1);
      check("stall_line_err", bus.line_err, 0);
      finish_line(1, 1);

      // Reset mid-fill, then a clean refill
      start(32'h00004000);
      beat(32'h55555555, 0, 0);
      beat(32'h66666666, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("midrst_req_ready", bus.req_ready, 1);
      check("midrst_crit_valid", bus.crit_valid, 0);
      check("midrst_crit_data", bus.crit_data, 0);
      check("midrst_line_valid", bus.line_valid, 0);
      check("midrst_line_data", bus.line_data, 0);
      check("midrst_line_addr", bus.line_addr, 0);
      check("midrst_line_err", bus.line_err, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      tick();
      start(32'h00005000);
      beat(32'hAAAAAAAA, 0, 0);
      beat(32'hBBBBBBBB, 0, 0);
      beat(32'hCCCCCCCC, 0, 0);
      beat(32'hDDDDDDDD, 1, 0);
      check("rst_refill_data", bus.line_data, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
      check("rst_refill_err", bus.line_err, 0);
      finish_line(0, 0);

      // Random refills of 1..6 beats with gaps and noise
      for (int t = 0; t < 40; t++) begin
         start($urandom);
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) beat($urandom, k == n - 1, $urandom_range(0, 2));
         finish_line($urandom_range(0, 3), 1);
      end

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
